// File: rtl/expander_mailbox.sv
// Expander mailbox: DATA/STATUS/CTRL register slots bridging MCU traffic to TX/RX stream FIFOs.
// Optional RX level interrupt enabled by defining EXPANDER_MAILBOX_IRQ_EN.
module expander_mailbox #(
    parameter int DEPTH     = 16,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int IRQ_LEVEL = 1
) (
    input  logic        sysclk,
    input  logic        sysreset,
    output logic [15:0] data_r,
    input  logic        data_read,
    input  logic        data_load,
    output logic [15:0] status_r,
    output logic [15:0] ctrl_r,
    input  logic        ctrl_load,
    input  logic [15:0] load_data,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef EXPANDER_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      tx_mem_q [DEPTH];
    logic [15:0]      rx_mem_q [DEPTH];
    logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_flush, rx_flush, flag_clr;

    assign tx_full  = (tx_cnt_q == CNT_W'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_W'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    // Full is judged before any same-cycle pop, so a pop never makes room for a push.
    assign tx_push  = data_load && !tx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = data_read && !rx_empty;

    assign tx_flush = ctrl_load && load_data[0];
    assign rx_flush = ctrl_load && load_data[1];
    assign flag_clr = ctrl_load && load_data[2];

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 16'h0000 : tx_mem_q[tx_rptr_q];
    assign rx_ready = !rx_full;
    assign data_r   = rx_empty ? 16'h0000 : rx_mem_q[rx_rptr_q];
    assign ctrl_r   = 16'h0000;
    assign status_r = {tx_full, tx_empty, rx_full, rx_empty, tx_ovf_q, rx_udf_q,
                       5'(tx_cnt_q), 5'(rx_cnt_q)};

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_ovf_d  = tx_ovf_q;
        rx_udf_d  = rx_udf_q;

        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + PTR_W'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_W'(1);
            if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_W'(1);
            else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end

        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + PTR_W'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_W'(1);
            if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_W'(1);
            else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end

        // A fresh fault in the same cycle as a clear stays visible.
        if (flag_clr) begin
            tx_ovf_d = 1'b0;
            rx_udf_d = 1'b0;
        end
        if (data_load && tx_full) tx_ovf_d = 1'b1;
        if (data_read && rx_empty) rx_udf_d = 1'b1;
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
        end
    end

    // Storage needs no reset: outputs are masked by the empty flags.
    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= load_data;
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end

`ifdef EXPANDER_MAILBOX_IRQ_EN
    logic irq_q;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) irq_q <= 1'b0;
        else          irq_q <= (rx_cnt_q >= CNT_W'(IRQ_LEVEL));
    end

    assign irq = irq_q;
`else
    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_irq_level_out_of_range
    end
`endif

endmodule

// File: tb/tb_expander_mailbox.sv
// Scoreboard bench for expander_mailbox; define EXPANDER_MAILBOX_IRQ_EN to also exercise irq.
module tb_expander_mailbox;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [15:0] data_r;
    logic        data_read;
    logic        data_load;
    logic [15:0] status_r;
    logic [15:0] ctrl_r;
    logic        ctrl_load;
    logic [15:0] load_data;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
`ifdef EXPANDER_MAILBOX_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] tx_exp[$];
    logic [15:0] rx_exp[$];
    logic [15:0] exp_w;

    always #5 sysclk = ~sysclk;

    expander_mailbox #(.DEPTH(16), .IRQ_LEVEL(4)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .data_r(data_r), .data_read(data_read), .data_load(data_load),
        .status_r(status_r), .ctrl_r(ctrl_r), .ctrl_load(ctrl_load),
        .load_data(load_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef EXPANDER_MAILBOX_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic ctrl_write(input logic [15:0] v);
        ctrl_load = 1'b1; load_data = v;
        step();
        ctrl_load = 1'b0; load_data = '0;
    endtask

    task automatic rx_push(input logic [15:0] w);
        rx_valid = 1'b1; rx_data = w;
        if (rx_ready) rx_exp.push_back(w);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        sysreset = 1'b1;
        data_read = 0; data_load = 0; ctrl_load = 0; load_data = '0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        step(); step();
        checks++; if (status_r !== 16'h5000) begin failures++; $display("FAIL reset_status got=%h exp=%h", status_r, 16'h5000); end
        sysreset = 1'b0;
        step();
        checks++; if (status_r !== 16'h5000) begin failures++; $display("FAIL post_reset_status got=%h exp=%h", status_r, 16'h5000); end
        checks++; if ({tx_valid, rx_ready} !== 2'b01) begin failures++; $display("FAIL reset_valid_ready got=%b exp=01", {tx_valid, rx_ready}); end
        checks++; if ({data_r, tx_data, ctrl_r} !== 48'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {data_r, tx_data, ctrl_r}); end
    endtask

    task automatic drain_tx(input string name);
        tx_ready = 1'b1;
        for (int c = 0; c < 40 && tx_exp.size() > 0; c++) begin
            if (tx_valid) begin
                exp_w = tx_exp.pop_front();
                checks++; if (tx_data !== exp_w) begin failures++; $display("FAIL %s_word got=%h exp=%h", name, tx_data, exp_w); end
            end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (tx_exp.size() != 0) begin failures++; $display("FAIL %s_timeout left=%0d exp=0", name, tx_exp.size()); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL %s_empty tx_valid=%b exp=0", name, tx_valid); end
    endtask

    task automatic test_tx_order();
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_load = 1'b1; load_data = words[i]; tx_exp.push_back(words[i]);
            step();
        end
        data_load = 1'b0;
        checks++; if (status_r[9:5] !== 5'd3) begin failures++; $display("FAIL tx_count3 got=%0d exp=3", status_r[9:5]); end
        checks++; if (tx_data !== 16'h1111) begin failures++; $display("FAIL tx_head got=%h exp=1111", tx_data); end
        drain_tx("tx_order");
    endtask

    task automatic test_tx_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            data_load = 1'b1; load_data = 16'h0100 + 16'(i);
            if (i < 16) tx_exp.push_back(load_data);
            step();
        end
        data_load = 1'b0;
        checks++; if ({status_r[15], status_r[11], status_r[9:5]} !== {1'b1, 1'b1, 5'd16}) begin
            failures++; $display("FAIL tx_full_ovf got=%b/%b/%0d exp=1/1/16", status_r[15], status_r[11], status_r[9:5]); end
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL tx_full_valid got=%b exp=1", tx_valid); end
        // Push while full with a concurrent pop: the pushed word must still be dropped.
        data_load = 1'b1; load_data = 16'hBEEF; tx_ready = 1'b1;
        exp_w = tx_exp.pop_front();
        checks++; if (tx_data !== exp_w) begin failures++; $display("FAIL tx_full_pop got=%h exp=%h", tx_data, exp_w); end
        step();
        data_load = 1'b0; tx_ready = 1'b0;
        checks++; if (status_r[9:5] !== 5'd15) begin failures++; $display("FAIL tx_full_nopush got=%0d exp=15", status_r[9:5]); end
        drain_tx("tx_ovf_drain");
        checks++; if (status_r[11] !== 1'b1) begin failures++; $display("FAIL tx_ovf_sticky got=%b exp=1", status_r[11]); end
        ctrl_write(16'h0004);
        checks++; if (status_r !== 16'h5000) begin failures++; $display("FAIL tx_ovf_clear got=%h exp=5000", status_r); end
    endtask

    task automatic test_rx_read();
        rx_push(16'hA5A5);
        rx_push(16'h5A5A);
        checks++; if (status_r[4:0] !== 5'd2) begin failures++; $display("FAIL rx_count2 got=%0d exp=2", status_r[4:0]); end
        step();
        checks++; if (data_r !== rx_exp[0]) begin failures++; $display("FAIL rx_cycle1 got=%h exp=%h", data_r, rx_exp[0]); end
        data_read = 1'b1;
        exp_w = rx_exp.pop_front();
        checks++; if (data_r !== exp_w) begin failures++; $display("FAIL rx_sample got=%h exp=%h", data_r, exp_w); end
        step();
        data_read = 1'b0;
        checks++; if (status_r[4:0] !== 5'd1) begin failures++; $display("FAIL rx_count1 got=%0d exp=1", status_r[4:0]); end
        checks++; if (data_r !== rx_exp[0]) begin failures++; $display("FAIL rx_next_head got=%h exp=%h", data_r, rx_exp[0]); end
        data_read = 1'b1;
        exp_w = rx_exp.pop_front();
        checks++; if (data_r !== exp_w) begin failures++; $display("FAIL rx_sample2 got=%h exp=%h", data_r, exp_w); end
        step();
        data_read = 1'b0;
        checks++; if (status_r !== 16'h5000) begin failures++; $display("FAIL rx_drained got=%h exp=5000", status_r); end
    endtask

    task automatic test_rx_underflow_flush();
        data_read = 1'b1;
        step();
        data_read = 1'b0;
        checks++; if (status_r !== 16'h5400) begin failures++; $display("FAIL rx_udf got=%h exp=5400", status_r); end
        checks++; if (data_r !== 16'h0) begin failures++; $display("FAIL rx_udf_data got=%h exp=0", data_r); end
        rx_push(16'h1234);
        checks++; if (data_r !== rx_exp[0]) begin failures++; $display("FAIL rx_udf_ptr got=%h exp=%h", data_r, rx_exp[0]); end
        ctrl_write(16'h0004);
        checks++; if (status_r[10] !== 1'b0) begin failures++; $display("FAIL rx_udf_clear got=%b exp=0", status_r[10]); end
        for (int i = 1; i < 16; i++) rx_push(16'hD000 + 16'(i));
        checks++; if ({rx_ready, status_r[13], status_r[4:0]} !== {1'b0, 1'b1, 5'd16}) begin
            failures++; $display("FAIL rx_full got=%b/%b/%0d exp=0/1/16", rx_ready, status_r[13], status_r[4:0]); end
        checks++; if (data_r !== rx_exp[0]) begin failures++; $display("FAIL rx_full_head got=%h exp=%h", data_r, rx_exp[0]); end
        rx_valid = 1'b1; rx_data = 16'hFFFF; ctrl_load = 1'b1; load_data = 16'h0002;
        step();
        rx_valid = 1'b0; ctrl_load = 1'b0; load_data = '0;
        rx_exp.delete();
        checks++; if (status_r !== 16'h5000) begin failures++; $display("FAIL rx_flush got=%h exp=5000", status_r); end
        checks++; if ({rx_ready, data_r} !== {1'b1, 16'h0}) begin failures++; $display("FAIL rx_flush_out got=%b/%h exp=1/0000", rx_ready, data_r); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) rx_push(16'hC000 + 16'(i));
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_data = 16'hC003 + 16'(i); rx_exp.push_back(rx_data);
            data_read = 1'b1;
            exp_w = rx_exp.pop_front();
            checks++; if (data_r !== exp_w) begin failures++; $display("FAIL b2b_rx_word%0d got=%h exp=%h", i, data_r, exp_w); end
            step();
            checks++; if (status_r[4:0] !== 5'd3) begin failures++; $display("FAIL b2b_rx_count%0d got=%0d exp=3", i, status_r[4:0]); end
        end
        rx_valid = 1'b0; data_read = 1'b0;
        ctrl_write(16'h0002);
        rx_exp.delete();
        for (int i = 0; i < 2; i++) begin
            data_load = 1'b1; load_data = 16'hE000 + 16'(i); tx_exp.push_back(load_data);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            data_load = 1'b1; load_data = 16'hE002 + 16'(i); tx_exp.push_back(load_data);
            tx_ready = 1'b1;
            exp_w = tx_exp.pop_front();
            checks++; if (tx_data !== exp_w) begin failures++; $display("FAIL b2b_tx_word%0d got=%h exp=%h", i, tx_data, exp_w); end
            step();
            checks++; if (status_r[9:5] !== 5'd2) begin failures++; $display("FAIL b2b_tx_count%0d got=%0d exp=2", i, status_r[9:5]); end
        end
        data_load = 1'b0; tx_ready = 1'b0;
        drain_tx("b2b_tx_drain");
    endtask

    task automatic test_tx_flush_and_async_reset();
        for (int i = 0; i < 3; i++) begin
            data_load = 1'b1; load_data = 16'h7000 + 16'(i);
            step();
        end
        data_load = 1'b1; load_data = 16'h0001; ctrl_load = 1'b1; tx_ready = 1'b1;
        step();
        data_load = 1'b0; ctrl_load = 1'b0; tx_ready = 1'b0; load_data = '0;
        checks++; if ({tx_valid, status_r[14], status_r[9:5]} !== {1'b0, 1'b1, 5'd0}) begin
            failures++; $display("FAIL tx_flush got=%b/%b/%0d exp=0/1/0", tx_valid, status_r[14], status_r[9:5]); end
        data_load = 1'b1; load_data = 16'h4242;
        step();
        data_load = 1'b0;
        rx_push(16'h4343);
        #2 sysreset = 1'b1;
        #1;
        checks++; if ({status_r, tx_valid, data_r, tx_data} !== {16'h5000, 1'b0, 16'h0, 16'h0}) begin
            failures++; $display("FAIL async_reset got=%h/%b/%h/%h exp=5000/0/0000/0000", status_r, tx_valid, data_r, tx_data); end
        rx_exp.delete();
        step();
        sysreset = 1'b0;
        step();
    endtask

`ifdef EXPANDER_MAILBOX_IRQ_EN
    task automatic test_irq();
        for (int i = 0; i < 3; i++) rx_push(16'h9000 + 16'(i));
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", irq); end
        rx_push(16'h9003);
        checks++; if ({status_r[4:0], irq} !== {5'd4, 1'b0}) begin failures++; $display("FAIL irq_lag got=%0d/%b exp=4/0", status_r[4:0], irq); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        data_read = 1'b1;
        step();
        data_read = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_fall_lag got=%b exp=1", irq); end
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
        ctrl_write(16'h0002);
        rx_exp.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_rx_read();
        test_rx_underflow_flush();
        test_back_to_back();
        test_tx_flush_and_async_reset();
`ifdef EXPANDER_MAILBOX_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
